// File: rtl/plab5_mcore_mem_tdm_arbiter.sv
// plab5_mcore_mem_tdm_arbiter
//   Time-division-multiplexed arbiter that gives two L1 refill ports shared
//   access to one main-memory port. Time is cut into fixed slots that
//   alternate between security domain 0 and domain 1. Only a requester tagged
//   with the current slot's domain can be granted, and only while enough of
//   the slot remains for a full round trip. This keeps one domain's traffic
//   from changing when the other domain is served. One transaction is in
//   flight at a time.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   reqN_val/rdy/msg/domain    request from requester N (N = 0, 1)
//   req_val/rdy/msg/domain     request to memory
//   resp_val/rdy/msg/domain    response from memory
//   respN_val/rdy/msg          response to requester N
//   cur_domain                 domain that owns the current slot
//   slot_err                   sticky: a transaction ran past its slot end
module plab5_mcore_mem_tdm_arbiter #(
  parameter int unsigned p_req_nbits    = 77,
  parameter int unsigned p_resp_nbits   = 47,
  parameter int unsigned p_slot_cycles  = 16,
  parameter int unsigned p_guard_cycles = 6
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [p_req_nbits-1:0]  req0_msg,
  input  logic                    req0_domain,

  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [p_req_nbits-1:0]  req1_msg,
  input  logic                    req1_domain,

  output logic                    req_val,
  input  logic                    req_rdy,
  output logic [p_req_nbits-1:0]  req_msg,
  output logic                    req_domain,

  input  logic                    resp_val,
  output logic                    resp_rdy,
  input  logic [p_resp_nbits-1:0] resp_msg,
  input  logic                    resp_domain,

  output logic                    resp0_val,
  input  logic                    resp0_rdy,
  output logic [p_resp_nbits-1:0] resp0_msg,

  output logic                    resp1_val,
  input  logic                    resp1_rdy,
  output logic [p_resp_nbits-1:0] resp1_msg,

  output logic                    cur_domain,
  output logic                    slot_err
);

  localparam int unsigned CntW = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
  localparam logic [CntW-1:0] LastCnt      = CntW'(p_slot_cycles - 1);
  // Last slot_cnt value at which remaining >= p_guard_cycles still holds.
  localparam logic [CntW-1:0] LastGrantCnt = CntW'(p_slot_cycles - 1 - p_guard_cycles);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                  state_q,      state_d;
  logic [CntW-1:0]         slot_cnt_q,   slot_cnt_d;
  logic                    cur_domain_q, cur_domain_d;
  logic                    rr_ptr_q,     rr_ptr_d;
  logic                    owner_q,      owner_d;
  logic                    slot_err_q,   slot_err_d;
  logic [p_req_nbits-1:0]  req_buf_q,    req_buf_d;
  logic [p_resp_nbits-1:0] resp_buf_q,   resp_buf_d;

  logic grant_window;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // Eligibility and grant selection. The reset term keeps the request
  // ready outputs low while reset is held, since they are combinational.
  always_comb begin
    grant_window = (state_q == ST_IDLE) && (slot_cnt_q <= LastGrantCnt) && reset;
    elig0        = grant_window && req0_val && (req0_domain == cur_domain_q);
    elig1        = grant_window && req1_val && (req1_domain == cur_domain_q);
    // rr_ptr names the last winner; on a tie the other requester goes.
    grant0       = elig0 && (!elig1 || rr_ptr_q);
    grant1       = elig1 && !grant0;
  end

  always_comb begin
    req0_rdy   = grant0;
    req1_rdy   = grant1;
    req_val    = (state_q == ST_REQ);
    req_msg    = req_buf_q;
    req_domain = (state_q == ST_REQ) && cur_domain_q;
    resp_rdy   = (state_q == ST_WAIT) && (resp_domain == cur_domain_q);
    resp0_val  = (state_q == ST_RESP) && !owner_q;
    resp1_val  = (state_q == ST_RESP) && owner_q;
    resp0_msg  = resp_buf_q;
    resp1_msg  = resp_buf_q;
    cur_domain = cur_domain_q;
    slot_err   = slot_err_q;
  end

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    cur_domain_d = cur_domain_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    slot_err_d   = slot_err_q;
    req_buf_d    = req_buf_q;
    resp_buf_d   = resp_buf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          state_d   = ST_REQ;
          owner_d   = grant1;
          rr_ptr_d  = grant1;
          req_buf_d = grant1 ? req1_msg : req0_msg;
        end
      end
      ST_REQ: begin
        if (req_rdy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_val && resp_rdy) begin
          resp_buf_d = resp_msg;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_q ? resp1_rdy : resp0_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // At the slot end the counter parks until the FSM is idle; the domain
    // switch happens on that first idle cycle, so an overrun only delays it.
    if (slot_cnt_q == LastCnt) begin
      if (state_q == ST_IDLE) begin
        slot_cnt_d   = '0;
        cur_domain_d = !cur_domain_q;
      end else begin
        slot_err_d   = 1'b1;
      end
    end else begin
      slot_cnt_d = slot_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      slot_cnt_q   <= '0;
      cur_domain_q <= 1'b0;
      rr_ptr_q     <= 1'b1;
      owner_q      <= 1'b0;
      slot_err_q   <= 1'b0;
      req_buf_q    <= '0;
      resp_buf_q   <= '0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      cur_domain_q <= cur_domain_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      slot_err_q   <= slot_err_d;
      req_buf_q    <= req_buf_d;
      resp_buf_q   <= resp_buf_d;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_tdm_arbiter.sv
// Randomized bench for plab5_mcore_mem_tdm_arbiter against a transaction-level
// model of the slot schedule and the single outstanding transaction.
module tb_plab5_mcore_mem_tdm_arbiter;

  localparam int REQ_W = 77;
  localparam int RESP_W = 47;
  localparam int SLOT = 16;
  localparam int GUARD = 6;

  logic              clk;
  logic              reset;
  logic              req0_val, req0_rdy, req0_domain;
  logic [REQ_W-1:0]  req0_msg;
  logic              req1_val, req1_rdy, req1_domain;
  logic [REQ_W-1:0]  req1_msg;
  logic              req_val, req_rdy, req_domain;
  logic [REQ_W-1:0]  req_msg;
  logic              resp_val, resp_rdy, resp_domain;
  logic [RESP_W-1:0] resp_msg;
  logic              resp0_val, resp0_rdy;
  logic [RESP_W-1:0] resp0_msg;
  logic              resp1_val, resp1_rdy;
  logic [RESP_W-1:0] resp1_msg;
  logic              cur_domain, slot_err;

  plab5_mcore_mem_tdm_arbiter #(
    .p_req_nbits   (REQ_W),
    .p_resp_nbits  (RESP_W),
    .p_slot_cycles (SLOT),
    .p_guard_cycles(GUARD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_val   (req0_val),
    .req0_rdy   (req0_rdy),
    .req0_msg   (req0_msg),
    .req0_domain(req0_domain),
    .req1_val   (req1_val),
    .req1_rdy   (req1_rdy),
    .req1_msg   (req1_msg),
    .req1_domain(req1_domain),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_msg    (req_msg),
    .req_domain (req_domain),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_msg   (resp_msg),
    .resp_domain(resp_domain),
    .resp0_val  (resp0_val),
    .resp0_rdy  (resp0_rdy),
    .resp0_msg  (resp0_msg),
    .resp1_val  (resp1_val),
    .resp1_rdy  (resp1_rdy),
    .resp1_msg  (resp1_msg),
    .cur_domain (cur_domain),
    .slot_err   (slot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  int               m_pos;       // cycles elapsed in the current slot
  bit               m_dom;
  bit               m_err;
  bit               m_last;      // requester granted most recently
  bit               m_busy;      // a transaction is in flight
  bit               m_issued;    // memory accepted its request
  bit               m_answered;  // memory response captured
  bit               m_who;
  logic [REQ_W-1:0]  m_req;
  logic [RESP_W-1:0] m_resp;

  task automatic model_reset();
    m_pos = 0; m_dom = 0; m_err = 0; m_last = 1;
    m_busy = 0; m_issued = 0; m_answered = 0; m_who = 0;
    m_req = '0; m_resp = '0;
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Stimulus profiles: req valid, mem req ready, mem resp valid,
  // resp domain matches, requester resp ready (percent).
  int prof_val[7]   = '{ 0, 60, 90, 70, 50,  80, 40};
  int prof_qrdy[7]  = '{ 0, 70, 90, 50, 30, 100, 80};
  int prof_pval[7]  = '{ 0, 60, 90,  5, 40, 100, 20};
  int prof_match[7] = '{ 0, 70,100, 80, 30, 100, 50};
  int prof_prdy[7]  = '{ 0, 70, 90, 50, 30, 100, 60};

  task automatic drive_random(input int p);
    logic [95:0] w;
    req0_val = chance(prof_val[p]);
    req1_val = chance(prof_val[p]);
    req0_domain = $urandom_range(1);
    req1_domain = $urandom_range(1);
    w = {$urandom(), $urandom(), $urandom()}; req0_msg = w[REQ_W-1:0];
    w = {$urandom(), $urandom(), $urandom()}; req1_msg = w[REQ_W-1:0];
    w = {$urandom(), $urandom(), $urandom()}; resp_msg = w[RESP_W-1:0];
    req_rdy = chance(prof_qrdy[p]);
    resp_val = chance(prof_pval[p]);
    resp_domain = chance(prof_match[p]) ? m_dom : !m_dom;
    resp0_rdy = chance(prof_prdy[p]);
    resp1_rdy = chance(prof_prdy[p]);
  endtask

  task automatic run_cycles(input int n, input int p);
    int  left;
    bit  e0, e1, pick0, pick1, x_qval, x_prdy, x_r0, x_r1, idle_now;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive_random(p);
      #1;
      left  = SLOT - 1 - m_pos;
      e0    = !m_busy && left >= GUARD && req0_val && req0_domain == m_dom;
      e1    = !m_busy && left >= GUARD && req1_val && req1_domain == m_dom;
      pick0 = e0 && (!e1 || m_last == 1'b1);
      pick1 = e1 && !pick0;
      x_qval = m_busy && !m_issued;
      x_prdy = m_busy && m_issued && !m_answered && resp_domain == m_dom;
      x_r0   = m_busy && m_answered && m_who == 1'b0;
      x_r1   = m_busy && m_answered && m_who == 1'b1;

      chk("req0_rdy", req0_rdy, pick0);
      chk("req1_rdy", req1_rdy, pick1);
      chk("req_val", req_val, x_qval);
      chk("resp_rdy", resp_rdy, x_prdy);
      chk("resp0_val", resp0_val, x_r0);
      chk("resp1_val", resp1_val, x_r1);
      chk("cur_domain", cur_domain, m_dom);
      chk("slot_err", slot_err, m_err);
      if (x_qval) begin
        chk("req_msg", req_msg, m_req);
        chk("req_domain", req_domain, m_dom);
      end
      if (x_r0) chk("resp0_msg", resp0_msg, m_resp);
      if (x_r1) chk("resp1_msg", resp1_msg, m_resp);

      // advance the model across the coming rising edge
      idle_now = !m_busy;
      if (pick0 || pick1) begin
        m_busy = 1; m_issued = 0; m_answered = 0;
        m_who  = pick1;
        m_last = pick1;
        m_req  = pick1 ? req1_msg : req0_msg;
      end else if (x_qval && req_rdy) begin
        m_issued = 1;
      end else if (x_prdy && resp_val) begin
        m_answered = 1;
        m_resp = resp_msg;
      end else if ((x_r0 && resp0_rdy) || (x_r1 && resp1_rdy)) begin
        m_busy = 0;
      end
      if (m_pos == SLOT - 1) begin
        if (idle_now) begin
          m_pos = 0;
          m_dom = !m_dom;
        end else begin
          m_err = 1;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string when_tag);
    chk({when_tag, ":req0_rdy"}, req0_rdy, 1'b0);
    chk({when_tag, ":req1_rdy"}, req1_rdy, 1'b0);
    chk({when_tag, ":req_val"}, req_val, 1'b0);
    chk({when_tag, ":resp_rdy"}, resp_rdy, 1'b0);
    chk({when_tag, ":resp0_val"}, resp0_val, 1'b0);
    chk({when_tag, ":resp1_val"}, resp1_val, 1'b0);
    chk({when_tag, ":req_msg"}, req_msg, '0);
    chk({when_tag, ":resp0_msg"}, resp0_msg, '0);
    chk({when_tag, ":resp1_msg"}, resp1_msg, '0);
    chk({when_tag, ":req_domain"}, req_domain, 1'b0);
    chk({when_tag, ":cur_domain"}, cur_domain, 1'b0);
    chk({when_tag, ":slot_err"}, slot_err, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle, held across an edge.
  task automatic pulse_reset(input int p);
    @(negedge clk);
    drive_random(p);
    req0_val = 1; req0_domain = 0;
    reset = 0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    #3;
    reset = 1;
    model_reset();
  endtask

  initial begin
    reset = 0;
    req0_val = 0; req1_val = 0; req0_domain = 0; req1_domain = 0;
    req0_msg = '0; req1_msg = '0; req_rdy = 0;
    resp_val = 0; resp_domain = 0; resp_msg = '0;
    resp0_rdy = 0; resp1_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    #3;
    reset = 1;

    run_cycles(40, 0);          // idle: plain 16-cycle domain alternation
    for (int p = 1; p < 7; p++) begin
      run_cycles(600, p);
      pulse_reset(p);
    end
    run_cycles(300, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
